// File: rtl/pla_seq_pkg.sv
// ============================================================================
// Module      : pla_seq_pkg
// Description : Shared types and constants for the PLA vector sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pla_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } pla_seq_state_e;

  localparam int CNT_W = 5;

  // Bit n set means the output is 1 for vector index n = {A,B,C,D}.
  localparam logic [15:0] Y_MINTERMS = 16'h8801;
  localparam logic [15:0] Z_MINTERMS = 16'h4020;

endpackage

`default_nettype wire

// File: rtl/pla_ref_model.sv
// ============================================================================
// Module      : pla_ref_model
// Description : Combinational golden PLA; expected Y/Z for a 4-bit vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pla_ref_model
  import pla_seq_pkg::*;
(
  input  logic [3:0] vec_i,
  output logic       exp_y_o,
  output logic       exp_z_o
);

  assign exp_y_o = Y_MINTERMS[vec_i];
  assign exp_z_o = Z_MINTERMS[vec_i];

endmodule

`default_nettype wire

// File: rtl/pla_vector_sequencer.sv
// ============================================================================
// Module      : pla_vector_sequencer
// Description : Walks all 16 input vectors of a 4-input PLA, checks Y/Z and
//               tallies pass/fail. Define PLA_SEQ_STOP_ON_FAIL_EN to end the
//               run at the first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pla_vector_sequencer
  import pla_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  input  logic             Y,
  input  logic             Z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [3:0]       first_fail_vec
);

  localparam logic [3:0]       c_settle_last = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

  pla_seq_state_e   state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic [3:0]       abcd_q, abcd_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [3:0]       first_fail_q, first_fail_d;

  logic w_exp_y;
  logic w_exp_z;
  logic w_match;
  logic w_end_run;

  pla_ref_model u_ref (
    .vec_i   (vec_q),
    .exp_y_o (w_exp_y),
    .exp_z_o (w_exp_z)
  );

  // Case equality so an unknown response never counts as a pass.
  assign w_match = (Y === w_exp_y) && (Z === w_exp_z);

`ifdef PLA_SEQ_STOP_ON_FAIL_EN
  assign w_end_run = (vec_q == 4'd15) || !w_match;
`else
  assign w_end_run = (vec_q == 4'd15);
`endif

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_cnt_d = settle_cnt_q;
    abcd_d       = abcd_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    first_fail_d = first_fail_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_SETTLE;
          vec_d        = 4'd0;
          settle_cnt_d = 4'd0;
          abcd_d       = 4'd0;
          pass_d       = '0;
          fail_d       = '0;
          first_fail_d = 4'd0;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == c_settle_last) begin
          state_d = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        settle_cnt_d = 4'd0;
        if (w_match) begin
          pass_d = pass_q + c_cnt_one;
        end else begin
          fail_d = fail_q + c_cnt_one;
          if (fail_q == '0) begin
            first_fail_d = vec_q;
          end
        end
        if (w_end_run) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + 4'd1;
          abcd_d  = vec_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= 4'd0;
      settle_cnt_q <= 4'd0;
      abcd_q       <= 4'd0;
      pass_q       <= '0;
      fail_q       <= '0;
      first_fail_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_cnt_q <= settle_cnt_d;
      abcd_q       <= abcd_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign {A, B, C, D}   = abcd_q;
  assign busy           = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done           = (state_q == ST_DONE);
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_vec = first_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_pla_vector_sequencer.sv
// ============================================================================
// Module      : tb_pla_vector_sequencer
// Description : Self-checking bench for pla_vector_sequencer with a
//               behavioural PLA under test and fault injection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pla_vector_sequencer;

  localparam int S = 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       A, B, C, D, Y, Z, busy, done;
  logic [4:0] pass_count, fail_count;
  logic [3:0] first_fail_vec;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          fault_mode = 0;
  logic [15:0] flip_y = 16'h0;
  logic [15:0] flip_z = 16'h0;

  typedef struct {
    int mode;
    int pc;
    int fc;
    int ff;
    int nv;
  } vec_t;

  vec_t tbl [3];

  always #5 clk = ~clk;

  pla_vector_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .A              (A),
    .B              (B),
    .C              (C),
    .D              (D),
    .Y              (Y),
    .Z              (Z),
    .busy           (busy),
    .done           (done),
    .pass_count     (pass_count),
    .fail_count     (fail_count),
    .first_fail_vec (first_fail_vec)
  );

  function automatic logic good_y(input logic [3:0] v);
    return (v == 4'd0) || (v == 4'd11) || (v == 4'd15);
  endfunction

  function automatic logic good_z(input logic [3:0] v);
    return (v == 4'd5) || (v == 4'd14);
  endfunction

  // PLA under test: 0 good, 1 Y stuck-at-0, 2 Z inverted, 3 per-vector flips.
  function automatic logic [1:0] pla_resp(input logic [3:0] v, input int mode,
                                          input logic [15:0] fy, input logic [15:0] fz);
    logic y;
    logic z;
    y = good_y(v);
    z = good_z(v);
    case (mode)
      1: y = 1'b0;
      2: z = ~z;
      3: begin
        y = y ^ fy[v];
        z = z ^ fz[v];
      end
      default: ;
    endcase
    return {y, z};
  endfunction

  always_comb {Y, Z} = pla_resp({A, B, C, D}, fault_mode, flip_y, flip_z);

  task automatic model(input int mode, input logic [15:0] fy, input logic [15:0] fz,
                       output int pc, output int fc, output int ff, output int nv);
    pc = 0;
    fc = 0;
    ff = 0;
    nv = 0;
    for (int v = 0; v < 16; v++) begin
      nv++;
      if (pla_resp(4'(v), mode, fy, fz) == {good_y(4'(v)), good_z(4'(v))}) begin
        pc++;
      end else begin
        if (fc == 0) ff = v;
        fc++;
`ifdef PLA_SEQ_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input string tag, input int exp_pc, input int exp_fc,
                     input int exp_ff, input int exp_nv, input int inject);
    int cyc      = 0;
    int abcd_bad = 0;
    int busy_bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!done && cyc < 4000) begin
      if ({A, B, C, D} != 4'(cyc / (S + 1))) abcd_bad++;
      if (!busy) busy_bad++;
      start = (cyc == inject);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_cycles"}, cyc, exp_nv * (S + 1));
    check({tag, "_abcd_seq_errs"}, abcd_bad, 0);
    check({tag, "_busy_errs"}, busy_bad, 0);
    check({tag, "_pass"}, int'(pass_count), exp_pc);
    check({tag, "_fail"}, int'(fail_count), exp_fc);
    if (exp_fc != 0) check({tag, "_first_fail"}, int'(first_fail_vec), exp_ff);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_hold"}, int'(done), 1);
    check({tag, "_pass_hold"}, int'(pass_count), exp_pc);
    check({tag, "_fail_hold"}, int'(fail_count), exp_fc);
    check({tag, "_abcd_hold"}, int'({A, B, C, D}), exp_nv - 1);
  endtask

  initial begin
    int pc, fc, ff, nv;

`ifdef PLA_SEQ_STOP_ON_FAIL_EN
    tbl[0] = '{mode: 0, pc: 16, fc: 0,  ff: 0, nv: 16};
    tbl[1] = '{mode: 1, pc: 0,  fc: 1,  ff: 0, nv: 1};
    tbl[2] = '{mode: 2, pc: 0,  fc: 1,  ff: 0, nv: 1};
`else
    tbl[0] = '{mode: 0, pc: 16, fc: 0,  ff: 0, nv: 16};
    tbl[1] = '{mode: 1, pc: 13, fc: 3,  ff: 0, nv: 16};
    tbl[2] = '{mode: 2, pc: 0,  fc: 16, ff: 0, nv: 16};
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          int'({A, B, C, D, busy, done, pass_count, fail_count, first_fail_vec}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", int'({busy, done}), 0);

    for (int i = 0; i < 3; i++) begin
      fault_mode = tbl[i].mode;
      run($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].fc, tbl[i].ff, tbl[i].nv, -1);
    end

    // Asynchronous reset in the middle of vector 7's settle window.
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7 * (S + 1) + 1) @(posedge clk);
    #1;
    check("midrun_vec", int'({A, B, C, D}), 7);
    check("midrun_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_outputs",
          int'({A, B, C, D, busy, done, pass_count, fail_count, first_fail_vec}), 0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 16, 0, 0, 16, -1);

    // A start pulse while busy must not disturb the run.
    fault_mode = 3;
    flip_y     = 16'h0400;
    flip_z     = 16'h0000;
    model(fault_mode, flip_y, flip_z, pc, fc, ff, nv);
    run("start_busy", pc, fc, ff, nv, 3 * (S + 1) + 1);

    for (int r = 0; r < 6; r++) begin
      fault_mode = 3;
      flip_y     = (r == 0) ? 16'h0 : 16'($urandom & $urandom);
      flip_z     = (r == 0) ? 16'h0 : 16'($urandom & $urandom);
      model(fault_mode, flip_y, flip_z, pc, fc, ff, nv);
      run($sformatf("rand%0d", r), pc, fc, ff, nv, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
